// File: rtl/execute_if.sv
// execute_if: bundles the ID/EX operand bus feeding the execute stage and the
// execute results feeding EX/MEM.
//
// Handshake: there is no valid/ready pair on this bus. The stage consumes the
// ex_* fields every cycle. The only flow control is e_stall. While e_stall is
// 1, the upstream (master) side must hold every ex_* field stable. The
// downstream side must not capture the e_* results. A transfer completes on
// the first rising edge at which e_stall is 0.
//
// master modport: upstream/testbench side (drives ex_*, reads e_*).
// slave modport : the execute stage.
interface execute_if;
  // ID/EX -> execute
  logic [7:0]  ex_icode;
  logic [7:0]  ex_ifun;
  logic [31:0] ex_valA;
  logic [31:0] ex_valB;
  logic [31:0] ex_valC;
  logic [31:0] ex_valP;
  logic [7:0]  ex_dstE;
  logic [7:0]  ex_dstM;
  logic        cc_hold;
  // execute -> EX/MEM
  logic [7:0]  e_icode;
  logic [31:0] e_valA;
  logic [7:0]  e_dstM;
  logic [31:0] e_valE;
  logic        e_cnd;
  logic [7:0]  e_dstE;
  logic [2:0]  cc;
  logic        e_stall;
  // debug view of the multiplier FSM (0 = IDLE, 1 = BUSY, 2 = DONE)
  logic [1:0]  dbg_state;

  modport master (
    output ex_icode, ex_ifun, ex_valA, ex_valB, ex_valC, ex_valP,
           ex_dstE, ex_dstM, cc_hold,
    input  e_icode, e_valA, e_dstM, e_valE, e_cnd, e_dstE, cc, e_stall,
           dbg_state
  );

  modport slave (
    input  ex_icode, ex_ifun, ex_valA, ex_valB, ex_valC, ex_valP,
           ex_dstE, ex_dstM, cc_hold,
    output e_icode, e_valA, e_dstM, e_valE, e_cnd, e_dstE, cc, e_stall,
           dbg_state
  );
endinterface

// File: rtl/execute.sv
// execute: Y86 execute stage.
// Computes the ALU result e_valE from the ID/EX values. Evaluates the jump and
// cmov condition e_cnd against the current condition codes. Owns the CC
// register, which holds {ZF, SF, OF}.
//
// Ports:
//   clk - pipeline clock, rising edge
//   rst - asynchronous active-high reset
//   bus - execute_if.slave, which carries:
//         inputs : ex_icode, ex_ifun, ex_valA..ex_valP, ex_dstE, ex_dstM,
//                  cc_hold
//         outputs: e_icode, e_valA, e_dstM (pass-through), e_valE, e_cnd,
//                  e_dstE, cc, e_stall, dbg_state
//
// Optional feature: define EX_MUL_EN to turn OPL ifun 4 into MULL, a
// 32-iteration shift-add multiplier that stalls the pipe through e_stall.
// When EX_MUL_EN is undefined, ifun 4 is an invalid OPL and e_stall is tied
// to 0.
module execute (
  input logic     clk,
  input logic     rst,
  execute_if.slave bus
);
  localparam logic [7:0] I_RRMOVL = 8'h2;
  localparam logic [7:0] I_IRMOVL = 8'h3;
  localparam logic [7:0] I_RMMOVL = 8'h4;
  localparam logic [7:0] I_MRMOVL = 8'h5;
  localparam logic [7:0] I_OPL    = 8'h6;
  localparam logic [7:0] I_JXX    = 8'h7;
  localparam logic [7:0] I_CALL   = 8'h8;
  localparam logic [7:0] I_RET    = 8'h9;
  localparam logic [7:0] I_PUSHL  = 8'hA;
  localparam logic [7:0] I_POPL   = 8'hB;
  localparam logic [7:0] RNONE    = 8'h0F;
  localparam logic [2:0] CC_RESET = 3'b100;

  logic [2:0]  cc_q;
  logic        zf, sf, of;
  logic [31:0] alu_a, alu_b, alu_e;
  logic        alu_of, alu_ok;
  logic [7:0]  alu_fn;
  logic        is_opl;
  logic        cnd;
  logic        cc_we;

  assign {zf, sf, of} = cc_q;
  assign is_opl       = (bus.ex_icode == I_OPL);

  // Operand selection.
  always_comb begin
    alu_a = 32'h0;
    case (bus.ex_icode)
      I_RRMOVL, I_OPL:             alu_a = bus.ex_valA;
      I_IRMOVL, I_RMMOVL, I_MRMOVL: alu_a = bus.ex_valC;
      I_CALL, I_PUSHL:             alu_a = 32'hFFFF_FFFC;
      I_RET, I_POPL:               alu_a = 32'h0000_0004;
      default:                     alu_a = 32'h0;
    endcase
  end

  always_comb begin
    alu_b = 32'h0;
    case (bus.ex_icode)
      I_RMMOVL, I_MRMOVL, I_OPL, I_CALL, I_PUSHL, I_RET, I_POPL:
        alu_b = bus.ex_valB;
      default: alu_b = 32'h0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t  state;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_acc;
  logic [4:0]  mul_cnt;
  logic        is_mull;
  logic        mul_done;

  assign is_mull  = is_opl && (bus.ex_ifun == 8'd4);
  assign mul_done = (state == S_DONE) && is_mull;

  // The stall rises in the same cycle a MULL is first presented. That cycle
  // has no FSM state of its own, so the stall cannot be purely registered.
  // Gating with rst lets the stall drop as soon as reset asserts.
  assign bus.e_stall   = !rst && is_mull && (state != S_DONE);
  assign bus.dbg_state = state;

  // Shift-add multiplier. One partial product is added per BUSY cycle.
  // The counter runs from 31 down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mul_a   <= 32'h0;
      mul_b   <= 32'h0;
      mul_acc <= 32'h0;
      mul_cnt <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mull) begin
            mul_a   <= bus.ex_valA;
            mul_b   <= bus.ex_valB;
            mul_acc <= 32'h0;
            mul_cnt <= 5'd31;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!is_mull) begin
            // The instruction was withdrawn, so the partial result is dropped.
            state   <= S_IDLE;
            mul_cnt <= 5'd0;
          end else begin
            if (mul_b[0]) mul_acc <= mul_acc + mul_a;
            mul_a <= {mul_a[30:0], 1'b0};
            mul_b <= {1'b0, mul_b[31:1]};
            if (mul_cnt == 5'd0) state <= S_DONE;
            else mul_cnt <= mul_cnt - 5'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign bus.e_stall   = 1'b0;
  assign bus.dbg_state = 2'd0;
`endif

  // ALU. SUB computes B - A. alu_ok is 0 both for invalid functions and for a
  // multiply that has not finished yet.
  always_comb begin
    alu_fn = is_opl ? bus.ex_ifun : 8'd0;
    alu_e  = 32'h0;
    alu_of = 1'b0;
    alu_ok = 1'b1;
    case (alu_fn)
      8'd0: begin
        alu_e  = alu_b + alu_a;
        alu_of = (alu_a[31] == alu_b[31]) && (alu_e[31] != alu_a[31]);
      end
      8'd1: begin
        alu_e  = alu_b - alu_a;
        alu_of = (alu_a[31] != alu_b[31]) && (alu_e[31] != alu_b[31]);
      end
      8'd2: alu_e = alu_b & alu_a;
      8'd3: alu_e = alu_b ^ alu_a;
`ifdef EX_MUL_EN
      8'd4: begin
        alu_ok = mul_done;
        alu_e  = mul_done ? mul_acc : 32'h0;
      end
`endif
      default: alu_ok = 1'b0;
    endcase
  end

  assign cc_we = is_opl && !bus.cc_hold && alu_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cc_q <= CC_RESET;
    else if (cc_we) cc_q <= {(alu_e == 32'h0), alu_e[31], alu_of};
  end

  // The condition is evaluated against the CC value from before this
  // instruction's own update.
  always_comb begin
    cnd = 1'b1;
    if (bus.ex_icode == I_JXX || bus.ex_icode == I_RRMOVL) begin
      case (bus.ex_ifun)
        8'd0:    cnd = 1'b1;
        8'd1:    cnd = (sf ^ of) | zf;
        8'd2:    cnd = sf ^ of;
        8'd3:    cnd = zf;
        8'd4:    cnd = !zf;
        8'd5:    cnd = !(sf ^ of);
        8'd6:    cnd = !(sf ^ of) && !zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign bus.e_icode = bus.ex_icode;
  assign bus.e_valA  = bus.ex_valA;
  assign bus.e_dstM  = bus.ex_dstM;
  assign bus.e_valE  = alu_e;
  assign bus.e_cnd   = cnd;
  assign bus.e_dstE  = (bus.ex_icode == I_RRMOVL && !cnd) ? RNONE : bus.ex_dstE;
  assign bus.cc      = cc_q;

  // ex_valP is not used by this stage. It is reduced here so that it still
  // counts as consumed.
  logic unused_valp;
  assign unused_valp = ^bus.ex_valP;
endmodule
